fpdp_add_requester: RTL and testbench
=====================================

Name: fpdp_add_requester

Overview:
- Initiator-side controller for the double-precision adder's ready/done handshake.
- Accepts an operand pair, plus an add/subtract selector, from an upstream valid/ready channel.
- Drives the adder's input_a/input_b/ready, waits for done, then returns the 64-bit result with an error flag downstream.
- Sits between the Nth-root iteration sequencer and the fpdp adder core; a watchdog guards against a hung adder.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles to wait in each handshake phase before flagging an error.
- CNT_W, 7: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rset  in  1  asynchronous active-low reset
- req_valid  in  1  upstream request present
- req_a  in  64  IEEE-754 double operand A
- req_b  in  64  IEEE-754 double operand B
- req_sub  in  1  1 = compute A-B, 0 = compute A+B
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- rsp_valid  out  1  result available
- rsp_z  out  64  result word
- rsp_err  out  1  1 = watchdog expired, rsp_z forced to 0
- rsp_ready  in  1  downstream consumes the result
- add_input_a  out  64  to adder input_a
- add_input_b  out  64  to adder input_b
- add_ready  out  4  to adder ready; only 4'd0 and 4'd1 are ever driven
- add_output_z  in  64  from adder output_z
- add_done  in  4  from adder done; 4'd1 = complete, any other value = not complete

Behaviour:
- Reset (rset low, asynchronous):
  - state=IDLE, add_ready=0, add_input_a/b=0.
  - rsp_valid=0, rsp_z=0, rsp_err=0, watchdog=0.
  - Reset mid-transaction abandons the transaction with no response; add_ready drops immediately.
- req_ready = (state==IDLE); it is a combinational decode of state only.
- IDLE: on req_valid, register operands and go to ISSUE; otherwise hold.
  - add_input_a <= req_a.
  - add_input_b <= req_sub ? {~req_b[63], req_b[62:0]} : req_b. Only the sign bit flips; NaN/Inf are passed untouched.
- ISSUE: add_ready=1. Operands stay stable until state returns to IDLE.
  - add_done==4'd1: latch rsp_z<=add_output_z, rsp_err<=0, clear watchdog, go to RELEASE.
  - Else, watchdog reaching TIMEOUT_CYCLES-1: rsp_z<=0, rsp_err<=1, clear watchdog, go to RELEASE.
- RELEASE: add_ready=0 (four-phase return-to-zero).
  - add_done!=4'd1: go to RESP.
  - Else, watchdog expires: rsp_z<=0, rsp_err<=1, go to RESP.
- RESP: rsp_valid=1; rsp_z and rsp_err are held stable.
  - rsp_ready: go to IDLE, rsp_valid drops the next cycle.
  - No timeout in RESP; downstream may stall indefinitely.
- Latency, zero-wait case: accept at cycle 0 → add_ready high from cycle 1. If done is seen at cycle k, RELEASE starts at k+1, rsp_valid rises at k+2 at the earliest.
- Simultaneous rsp_ready and a new req_valid in RESP: the new request is not accepted until the cycle after IDLE is re-entered. There is no bypass; at most one transaction is outstanding.
- add_done already 4'd1 on entry to ISSUE (stale done): accepted as completion. The adder guarantees done returns to 0 when ready is 0.
- Watchdog: counts only in ISSUE and RELEASE, saturating; cleared on every state change.

Decomposition:
- Package fpdp_pkg:
  - state enum {IDLE, ISSUE, RELEASE, RESP}
  - constants HS_REQ=4'd1, HS_IDLE=4'd0, DONE_OK=4'd1, SIGN_BIT=63
- Sub-module fpdp_watchdog: parameterised saturating counter with clear/enable inputs and an expire output. Reused by the future multiply/divide requesters.

Test Plan:
- Add: A=0x3FF0000000000000 (1.0), B=0x4000000000000000 (2.0), req_sub=0; the bench adder model returns 0x4008000000000000 with done after 5 cycles.
  - Expect add_input_b=0x4000000000000000.
  - Expect add_ready high for 6 cycles.
  - Expect rsp_z=0x4008000000000000, rsp_err=0.
- Subtract: A=0x4008000000000000, B=0x3FF0000000000000, req_sub=1.
  - Expect add_input_b=0xBFF0000000000000.
  - With model result 0x4000000000000000, expect rsp_z=0x4000000000000000.
- Hung adder: done never asserts.
  - Expect add_ready to drop after exactly TIMEOUT_CYCLES=64 cycles in ISSUE.
  - Expect rsp_valid with rsp_err=1, rsp_z=0.
- Back-pressure: hold rsp_ready=0 for 20 cycles with req_valid=1 throughout.
  - Expect rsp_z stable and req_ready=0 for the whole stall.
  - After rsp_ready pulses, the next request is accepted exactly one cycle later.
- Reset mid-ISSUE: assert rset low while add_ready=1.
  - Expect add_ready=0 and rsp_valid=0 asynchronously, before the next clock edge.
  - After release, req_ready=1 and no response is emitted for the aborted request.
- Stuck done: model holds done=4'd1 after ready drops.
  - Expect RELEASE timeout, then rsp_err=1, rsp_z=0.

Source files
------------

// File: rtl/fpdp_pkg.sv
// Shared types and handshake constants for the fpdp core requesters.
`timescale 1ns/1ps
package fpdp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        RESP
    } state_t;

    localparam logic [3:0] HS_REQ   = 4'd1;
    localparam logic [3:0] HS_IDLE  = 4'd0;
    localparam logic [3:0] DONE_OK  = 4'd1;
    localparam int         SIGN_BIT = 63;

    // Negation touches only the sign bit, so NaN/Inf payloads pass through unchanged.
    function automatic logic [63:0] negate_fp(input logic [63:0] x);
        return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fpdp_watchdog.sv
// Saturating cycle counter that flags a stalled handshake phase.
`timescale 1ns/1ps
module fpdp_watchdog #(
    parameter int LIMIT = 64,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic rset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Counter parks on LAST so expire stays asserted until the owner clears it.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/fpdp_add_requester.sv
// Four-phase ready/done initiator for the double-precision adder, with a
// valid/ready request channel upstream and a result channel downstream.
`timescale 1ns/1ps
module fpdp_add_requester
    import fpdp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rset,
    input  logic        req_valid,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic        req_sub,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_z,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic [63:0] add_input_a,
    output logic [63:0] add_input_b,
    output logic [3:0]  add_ready,
    input  logic [63:0] add_output_z,
    input  logic [3:0]  add_done
);

    state_t state;
    state_t state_next;
    logic   load_ops;
    logic   latch_ok;
    logic   latch_err;
    logic   wd_clear;
    logic   wd_enable;
    logic   wd_expire;

    assign wd_enable = (state == ISSUE) || (state == RELEASE);
    assign wd_clear  = (state_next != state);

    fpdp_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rset   (rset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completion takes priority over a watchdog expiring in the same cycle.
    always_comb begin
        state_next = state;
        load_ops   = 1'b0;
        latch_ok   = 1'b0;
        latch_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    load_ops   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (add_done == DONE_OK) begin
                    latch_ok   = 1'b1;
                    state_next = RELEASE;
                end else if (wd_expire) begin
                    latch_err  = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (add_done != DONE_OK) begin
                    state_next = RESP;
                end else if (wd_expire) begin
                    latch_err  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are held from acceptance until the next request is taken.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            add_input_a <= '0;
            add_input_b <= '0;
        end else if (load_ops) begin
            add_input_a <= req_a;
            add_input_b <= req_sub ? negate_fp(req_b) : req_b;
        end
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            rsp_z   <= '0;
            rsp_err <= 1'b0;
        end else if (latch_ok) begin
            rsp_z   <= add_output_z;
            rsp_err <= 1'b0;
        end else if (latch_err) begin
            rsp_z   <= '0;
            rsp_err <= 1'b1;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign add_ready = (state == ISSUE) ? HS_REQ : HS_IDLE;

endmodule

// File: tb/tb_fpdp_add_requester.sv
// Scoreboard bench for fpdp_add_requester driving a behavioural adder model.
`timescale 1ns/1ps
module tb_fpdp_add_requester;
    import fpdp_pkg::*;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int CNT_W          = 7;

    typedef struct packed {
        logic [63:0] z;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rset = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        req_sub = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_z;
    logic        rsp_err;
    logic        rsp_ready = 1'b1;
    logic [63:0] add_input_a;
    logic [63:0] add_input_b;
    logic [3:0]  add_ready;
    logic [63:0] add_output_z;
    logic [3:0]  add_done;

    rsp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    int          model_delay = 5;
    logic        model_hang  = 1'b0;
    logic        model_stuck = 1'b0;
    logic [63:0] model_z     = '0;
    int          ready_cnt;

    always #5 clk = ~clk;

    fpdp_add_requester #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rset         (rset),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sub      (req_sub),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_z        (rsp_z),
        .rsp_err      (rsp_err),
        .rsp_ready    (rsp_ready),
        .add_input_a  (add_input_a),
        .add_input_b  (add_input_b),
        .add_ready    (add_ready),
        .add_output_z (add_output_z),
        .add_done     (add_done)
    );

    // Adder model: done rises model_delay cycles after ready, drops once ready
    // is low (unless stuck), and output_z is garbage whenever done is not 1.
    always @(posedge clk or negedge rset) begin
        if (!rset) begin
            ready_cnt <= 0;
            add_done  <= 4'd0;
        end else if (add_ready == 4'd1) begin
            ready_cnt <= ready_cnt + 1;
            if (!model_hang && (ready_cnt + 1 >= model_delay))
                add_done <= 4'd1;
        end else begin
            ready_cnt <= 0;
            if (!model_stuck)
                add_done <= 4'd0;
        end
    end

    assign add_output_z = (add_done == 4'd1) ? model_z : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every downstream handshake.
    always begin
        rsp_t exp_rsp;
        @(negedge clk);
        #1;
        if (rset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got z=0x%h err=%0d, expected no response",
                         rsp_z, rsp_err);
            end else begin
                exp_rsp = sb.pop_front();
                check_output("rsp_z", rsp_z, exp_rsp.z);
                check_output("rsp_err", 64'(rsp_err), 64'(exp_rsp.err));
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b, input logic sub);
        int n;
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got req_ready=0, expected 1 within 500 cycles");
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output(name, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int n;
        int bad;
        #1000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int n;
        int bad;

        repeat (3) @(negedge clk);
        check_output("rst_req_ready", 64'(req_ready), 64'd1);
        check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("rst_add_ready", 64'(add_ready), 64'd0);
        check_output("rst_add_input_a", add_input_a, 64'd0);
        check_output("rst_add_input_b", add_input_b, 64'd0);
        check_output("rst_rsp_z", rsp_z, 64'd0);
        check_output("rst_rsp_err", 64'(rsp_err), 64'd0);
        rset = 1'b1;
        @(negedge clk);

        // 1.0 + 2.0 = 3.0 with a 5-cycle adder
        model_delay = 5;
        model_z     = 64'h4008_0000_0000_0000;
        sb.push_back('{z: 64'h4008_0000_0000_0000, err: 1'b0});
        apply_stimulus(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
        check_output("add_input_a_add", add_input_a, 64'h3FF0_0000_0000_0000);
        check_output("add_input_b_add", add_input_b, 64'h4000_0000_0000_0000);
        n = 0;
        while (add_ready == 4'd1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_output("add_ready_cycles", 64'(n), 64'd6);
        wait_idle("idle_after_add");

        // 3.0 - 1.0 = 2.0, sign of B flipped on the adder side
        model_z = 64'h4000_0000_0000_0000;
        sb.push_back('{z: 64'h4000_0000_0000_0000, err: 1'b0});
        apply_stimulus(64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1);
        check_output("add_input_b_sub", add_input_b, 64'hBFF0_0000_0000_0000);
        wait_idle("idle_after_sub");

        // Hung adder: ISSUE times out after exactly TIMEOUT_CYCLES
        model_hang = 1'b1;
        sb.push_back('{z: 64'd0, err: 1'b1});
        apply_stimulus(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0);
        n = 0;
        while (add_ready == 4'd1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_output("hung_ready_cycles", 64'(n), 64'd64);
        model_hang = 1'b0;
        wait_idle("idle_after_hung");

        // Back-pressure: 2.0 + 3.0 = 5.0 held while a new request waits
        rsp_ready   = 1'b0;
        model_delay = 2;
        model_z     = 64'h4014_0000_0000_0000;
        sb.push_back('{z: 64'h4014_0000_0000_0000, err: 1'b0});
        apply_stimulus(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b0);
        n = 0;
        while (!rsp_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_output("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        model_z = 64'h4010_0000_0000_0000;
        sb.push_back('{z: 64'h4010_0000_0000_0000, err: 1'b0});
        req_a     = 64'h3FF0_0000_0000_0000;
        req_b     = 64'h4008_0000_0000_0000;
        req_sub   = 1'b0;
        req_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            if (rsp_z !== 64'h4014_0000_0000_0000 || req_ready !== 1'b0 || rsp_valid !== 1'b1)
                bad++;
            @(negedge clk);
        end
        check_output("bp_stall_violations", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("bp_idle_after_pulse", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("bp_next_accepted", 64'(add_ready), 64'd1);
        check_output("bp_next_input_a", add_input_a, 64'h3FF0_0000_0000_0000);
        wait_idle("idle_after_bp");

        // Reset while ISSUE is active: no response for the aborted request
        model_hang = 1'b1;
        apply_stimulus(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
        check_output("pre_reset_add_ready", 64'(add_ready), 64'd1);
        #2;
        rset = 1'b0;
        #1;
        check_output("async_rst_add_ready", 64'(add_ready), 64'd0);
        check_output("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rset       = 1'b1;
        model_hang = 1'b0;
        check_output("post_reset_req_ready", 64'(req_ready), 64'd1);
        repeat (10) @(negedge clk);
        check_output("post_reset_no_rsp", 64'(rsp_valid), 64'd0);

        // Stuck done: RELEASE times out
        model_delay = 3;
        model_stuck = 1'b1;
        model_z     = 64'h4020_0000_0000_0000;
        sb.push_back('{z: 64'd0, err: 1'b1});
        apply_stimulus(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
        n = 0;
        while (add_ready == 4'd1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (!rsp_valid && n < 300) begin
            n++;
            @(negedge clk);
        end
        check_output("stuck_release_cycles", 64'(n), 64'd64);
        model_stuck = 1'b0;
        wait_idle("idle_after_stuck");

        repeat (3) @(negedge clk);
        check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
